memory_cycle: RTL and testbench

Memory (M) stage of the 5-stage RV32I pipeline. It consumes the E/M pipeline register outputs (`memory_signals`, `Result_M`, `rs2_data_M`) and performs load/store accesses on a req/ack data-memory port with variable latency. While an access is outstanding it stalls the pipeline. It then forms the M/W pipeline register that drives writeback and the `rd_data_W` forwarding path.

---
 rtl/memory_cycle.sv | 192 +++++++++++++++++++
 tb/tb_memory_cycle.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RV32I memory stage: req/ack data-memory access, stall, M/W register
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   memory_signals             E/M control bundle (memory_info)
//   Result_M, rs2_data_M       effective address / ALU result, store data
//   dmem_req_o .. dmem_wdata_o data-memory request side
//   dmem_ack_i, dmem_rdata_i   data-memory completion side
//   stall_mem_o                holds IF..E/M while an access is outstanding
//   bus_err_o, misalign_o      one-cycle registered event pulses
//   rd_wren_W, rd_addr_W, rd_data_W   M/W pipeline register
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses).

package memory_cycle_pkg;
    typedef struct packed {
        logic       rd_wren;
        logic [4:0] rd_addr;
        logic       mem_wren;
        logic       mem_load;
        logic [1:0] mem_size;
        logic       mem_unsign;
    } memory_info;
endpackage

module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  memory_info  memory_signals,
    input  logic [31:0] Result_M,
    input  logic [31:0] rs2_data_M,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_mem_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic        rd_wren_W,
    output logic [4:0]  rd_addr_W,
    output logic [31:0] rd_data_W
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_q, misalign_d;
    logic        rd_wren_q, rd_wren_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        mem_op, misaligned, access, abort, stall;
    logic [1:0]  a;
    logic [3:0]  be;
    logic [31:0] wdata, load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign a      = Result_M[1:0];
    assign mem_op = memory_signals.mem_load | memory_signals.mem_wren;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = mem_op &
                        (((memory_signals.mem_size == 2'b01) & a[0]) |
                         (memory_signals.mem_size[1] & (a != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign access = mem_op & ~misaligned;
    // Ack on the final cycle wins over the timeout.
    assign abort  = access & (state_q == S_WAIT) & ~dmem_ack_i &
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign stall  = access & ~dmem_ack_i & ~abort;

    always_comb begin
        be       = 4'b1111;
        wdata    = rs2_data_M;
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        load_ext = dmem_rdata_i;
        case (memory_signals.mem_size)
            2'b00: begin
                be    = 4'b0001 << a;
                wdata = {4{rs2_data_M[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {a[1], 1'b0};
                wdata = {2{rs2_data_M[15:0]}};
            end
            default: ;
        endcase
        case (a)
            2'b00:   ld_byte = dmem_rdata_i[7:0];
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = a[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        if (memory_signals.mem_size == 2'b00) begin
            load_ext = memory_signals.mem_unsign ? {24'h0, ld_byte}
                                                 : {{24{ld_byte[7]}}, ld_byte};
        end else if (memory_signals.mem_size == 2'b01) begin
            load_ext = memory_signals.mem_unsign ? {16'h0, ld_half}
                                                 : {{16{ld_half[15]}}, ld_half};
        end
    end

    // Bus outputs are gated by reset so a reset mid-access drops the request at once.
    always_comb begin
        dmem_req_o   = access & ~rst_i;
        dmem_we_o    = dmem_req_o & memory_signals.mem_wren;
        dmem_addr_o  = dmem_req_o ? {Result_M[31:2], 2'b00} : 32'h0;
        dmem_be_o    = dmem_req_o ? be : 4'b0000;
        dmem_wdata_o = dmem_we_o ? wdata : 32'h0;
        stall_mem_o  = stall & ~rst_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (access && !dmem_ack_i) begin
                    state_d = S_WAIT;
                    // The IDLE request cycle counts as the first waited cycle.
                    cnt_d   = CW'(1);
                end
            end
            default: begin
                if (!access || dmem_ack_i || abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus_err_d  = abort;
        misalign_d = misaligned;
        rd_wren_d  = 1'b0;
        rd_addr_d  = 5'd0;
        rd_data_d  = 32'h0;
        if (!stall && !abort && !misaligned) begin
            rd_wren_d = memory_signals.rd_wren & ~memory_signals.mem_wren;
            rd_addr_d = memory_signals.rd_addr;
            rd_data_d = (access && memory_signals.mem_load && !memory_signals.mem_wren)
                        ? load_ext : Result_M;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            rd_wren_q  <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
            rd_wren_q  <= rd_wren_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus_err_o  = bus_err_q;
    assign misalign_o = misalign_q;
    assign rd_wren_W  = rd_wren_q;
    assign rd_addr_W  = rd_addr_q;
    assign rd_data_W  = rd_data_q;

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - self-checking bench for memory_cycle

module tb_memory_cycle;
    import memory_cycle_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    memory_info  memory_signals;
    logic [31:0] Result_M, rs2_data_M;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_mem_o, bus_err_o, misalign_o;
    logic        rd_wren_W;
    logic [4:0]  rd_addr_W;
    logic [31:0] rd_data_W;

    typedef struct packed {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
    } mw_t;

    mw_t sb_q[$];
    mw_t exp_mw;
    int  n_cmp = 0;
    int  n_bad = 0;

    int          stalls, reqs;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen, addr_seen;
    logic        we_seen;

    memory_cycle #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .memory_signals(memory_signals),
        .Result_M(Result_M), .rs2_data_M(rs2_data_M),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_mem_o(stall_mem_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o),
        .rd_wren_W(rd_wren_W), .rd_addr_W(rd_addr_W), .rd_data_W(rd_data_W)
    );

    always #5 clk_i = ~clk_i;

    function automatic memory_info mk(input logic wr, input logic [4:0] rd, input logic st,
                                      input logic ld, input logic [1:0] sz, input logic un);
        memory_info m;
        m.rd_wren = wr; m.rd_addr = rd; m.mem_wren = st;
        m.mem_load = ld; m.mem_size = sz; m.mem_unsign = un;
        return m;
    endfunction

    // Drives one instruction from a negedge; ack_after < 0 means never ack.
    // Returns at the negedge after the cycle in which the stage stopped stalling.
    task automatic run_access(input memory_info mi, input logic [31:0] res, input logic [31:0] rs2,
                              input int ack_after, input logic [31:0] rdata);
        logic done;
        memory_signals = mi; Result_M = res; rs2_data_M = rs2;
        stalls = 0; reqs = 0;
        for (int c = 0; c < 40; c++) begin
            dmem_ack_i   = (c == ack_after);
            dmem_rdata_i = (c == ack_after) ? rdata : 32'h0;
            #1;
            if (dmem_req_o) reqs++;
            if (stall_mem_o) stalls++;
            if (c == 0) begin
                be_seen = dmem_be_o; wd_seen = dmem_wdata_o;
                addr_seen = dmem_addr_o; we_seen = dmem_we_o;
            end
            done = !stall_mem_o;
            @(negedge clk_i);
            if (done) break;
        end
        memory_signals = '0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        memory_signals = mk(1, 5'd5, 0, 1, 2'b10, 0);
        Result_M = 32'h100; rs2_data_M = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        @(negedge clk_i);
        n_cmp++;
        if ({dmem_req_o, stall_mem_o, dmem_be_o, dmem_addr_o} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_bus: req=%b stall=%b be=%b addr=%h, want all 0",
                     dmem_req_o, stall_mem_o, dmem_be_o, dmem_addr_o);
        end
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W, bus_err_o, misalign_o} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_mw: wren=%b addr=%0d data=%h err=%b mis=%b, want all 0",
                     rd_wren_W, rd_addr_W, rd_data_W, bus_err_o, misalign_o);
        end
        memory_signals = '0;
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_lw_zero_wait();
        sb_q.push_back('{1'b1, 5'd5, 32'hDEADBEEF});
        run_access(mk(1, 5'd5, 0, 1, 2'b10, 0), 32'h100, 32'h0, 0, 32'hDEADBEEF);
        n_cmp++;
        if (stalls !== 0) begin n_bad++; $display("FAIL lw_stall: got %0d want 0", stalls); end
        n_cmp++;
        if ({addr_seen, be_seen} !== {32'h100, 4'b1111}) begin
            n_bad++; $display("FAIL lw_bus: addr=%h be=%b want 00000100 1111", addr_seen, be_seen);
        end
        exp_mw = sb_q.pop_front();
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
            n_bad++; $display("FAIL lw_mw: got %b/%0d/%h want %b/%0d/%h", rd_wren_W, rd_addr_W,
                              rd_data_W, exp_mw.wren, exp_mw.addr, exp_mw.data);
        end
    endtask

    task automatic test_sub_word_loads();
        // {size, unsign, addr, expected data}
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] ex  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        logic [3:0]  bex [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{1'b1, 5'd10, ex[i]});
            run_access(mk(1, 5'd10, 0, 1, sz[i], un[i]), ad[i], 32'h0, 3, 32'h80FF1234);
            n_cmp++;
            if ({stalls, be_seen} !== {32'd3, bex[i]}) begin
                n_bad++; $display("FAIL load%0d_stall_be: stalls=%0d be=%b want 3 %b",
                                  i, stalls, be_seen, bex[i]);
            end
            exp_mw = sb_q.pop_front();
            n_cmp++;
            if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
                n_bad++; $display("FAIL load%0d_mw: got %b/%0d/%h want %b/%0d/%h", i, rd_wren_W,
                                  rd_addr_W, rd_data_W, exp_mw.wren, exp_mw.addr, exp_mw.data);
            end
        end
    endtask

    task automatic test_stores();
        logic [1:0]  sz  [3] = '{2'b01, 2'b00, 2'b10};
        logic [31:0] ad  [3] = '{32'h202, 32'h201, 32'h304};
        logic [31:0] d   [3] = '{32'h0000ABCD, 32'h1234565A, 32'hCAFEF00D};
        logic [3:0]  bex [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] wex [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
        logic [31:0] aex [3] = '{32'h200, 32'h200, 32'h304};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{1'b0, 5'd3, ad[i]});
            run_access(mk(1, 5'd3, 1, 0, sz[i], 0), ad[i], d[i], 1, 32'h0);
            n_cmp++;
            if ({be_seen, wd_seen, we_seen, addr_seen} !== {bex[i], wex[i], 1'b1, aex[i]}) begin
                n_bad++; $display("FAIL store%0d_bus: be=%b wd=%h we=%b addr=%h want %b %h 1 %h",
                                  i, be_seen, wd_seen, we_seen, addr_seen, bex[i], wex[i], aex[i]);
            end
            exp_mw = sb_q.pop_front();
            n_cmp++;
            if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
                n_bad++; $display("FAIL store%0d_mw: got %b/%0d/%h want %b/%0d/%h", i, rd_wren_W,
                                  rd_addr_W, rd_data_W, exp_mw.wren, exp_mw.addr, exp_mw.data);
            end
        end
    endtask

    task automatic test_timeout();
        sb_q.push_back('{1'b0, 5'd0, 32'h0});
        run_access(mk(1, 5'd6, 0, 1, 2'b10, 0), 32'h400, 32'h0, -1, 32'h0);
        n_cmp++;
        if ({reqs, stalls} !== {32'd16, 32'd15}) begin
            n_bad++; $display("FAIL timeout_cycles: req=%0d stall=%0d want 16 15", reqs, stalls);
        end
        n_cmp++;
        if (bus_err_o !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", bus_err_o); end
        exp_mw = sb_q.pop_front();
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
            n_bad++; $display("FAIL timeout_mw: got %b/%0d/%h want bubble", rd_wren_W, rd_addr_W, rd_data_W);
        end
        @(negedge clk_i);
        n_cmp++;
        if ({bus_err_o, dmem_req_o} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_pulse: err=%b req=%b want 0 0", bus_err_o, dmem_req_o);
        end
        // Ack on the 16th request cycle completes normally.
        sb_q.push_back('{1'b1, 5'd6, 32'h600DF00D});
        run_access(mk(1, 5'd6, 0, 1, 2'b10, 0), 32'h400, 32'h0, 15, 32'h600DF00D);
        n_cmp++;
        if ({reqs, bus_err_o} !== {32'd16, 1'b0}) begin
            n_bad++; $display("FAIL late_ack: req=%0d err=%b want 16 0", reqs, bus_err_o);
        end
        exp_mw = sb_q.pop_front();
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
            n_bad++; $display("FAIL late_ack_mw: got %b/%0d/%h want %b/%0d/%h", rd_wren_W, rd_addr_W,
                              rd_data_W, exp_mw.wren, exp_mw.addr, exp_mw.data);
        end
    endtask

    task automatic test_misaligned_word();
        sb_q.push_back('{1'b1, 5'd8, 32'h11223344});
        run_access(mk(1, 5'd8, 0, 1, 2'b10, 0), 32'h102, 32'h0, 0, 32'h11223344);
        n_cmp++;
        if ({reqs, addr_seen, be_seen, misalign_o} !== {32'd1, 32'h100, 4'b1111, 1'b0}) begin
            n_bad++; $display("FAIL misalign_lw: req=%0d addr=%h be=%b mis=%b want 1 00000100 1111 0",
                              reqs, addr_seen, be_seen, misalign_o);
        end
        exp_mw = sb_q.pop_front();
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
            n_bad++; $display("FAIL misalign_mw: got %b/%0d/%h want %b/%0d/%h", rd_wren_W, rd_addr_W,
                              rd_data_W, exp_mw.wren, exp_mw.addr, exp_mw.data);
        end
    endtask

    task automatic test_non_mem_ack_ignored();
        sb_q.push_back('{1'b1, 5'd9, 32'h00000055});
        run_access(mk(1, 5'd9, 0, 0, 2'b00, 0), 32'h55, 32'h0, 0, 32'hBADBAD00);
        n_cmp++;
        if ({reqs, stalls} !== {32'd0, 32'd0}) begin
            n_bad++; $display("FAIL nonmem_bus: req=%0d stall=%0d want 0 0", reqs, stalls);
        end
        exp_mw = sb_q.pop_front();
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
            n_bad++; $display("FAIL nonmem_mw: got %b/%0d/%h want %b/%0d/%h", rd_wren_W, rd_addr_W,
                              rd_data_W, exp_mw.wren, exp_mw.addr, exp_mw.data);
        end
    endtask

    task automatic test_reset_mid_wait();
        memory_signals = mk(1, 5'd4, 0, 1, 2'b10, 0);
        Result_M = 32'h500; dmem_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({dmem_req_o, stall_mem_o, rd_wren_W, rd_addr_W, rd_data_W} !== 39'h0) begin
            n_bad++; $display("FAIL rst_mid: req=%b stall=%b wren=%b addr=%0d data=%h want all 0",
                              dmem_req_o, stall_mem_o, rd_wren_W, rd_addr_W, rd_data_W);
        end
        @(negedge clk_i);
        memory_signals = '0;
        rst_i = 1'b0;
        @(negedge clk_i);
        // A fresh access after reset must start from IDLE and time out after 16 cycles.
        sb_q.push_back('{1'b0, 5'd0, 32'h0});
        run_access(mk(1, 5'd4, 0, 1, 2'b10, 0), 32'h500, 32'h0, -1, 32'h0);
        n_cmp++;
        if ({reqs, bus_err_o} !== {32'd16, 1'b1}) begin
            n_bad++; $display("FAIL rst_idle: req=%0d err=%b want 16 1", reqs, bus_err_o);
        end
        exp_mw = sb_q.pop_front();
        n_cmp++;
        if ({rd_wren_W, rd_addr_W, rd_data_W} !== exp_mw) begin
            n_bad++; $display("FAIL rst_idle_mw: got %b/%0d/%h want bubble", rd_wren_W, rd_addr_W, rd_data_W);
        end
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_sub_word_loads();
        test_stores();
        test_timeout();
        test_misaligned_word();
        test_non_mem_ack_ignored();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
